// File: rtl/spike_tag_fifo_if.sv
// Bundles the push/pop handshake and status signals of spike_tag_fifo.
// master: the side that produces and consumes tags (neuron pipeline or bench).
// slave:  the FIFO itself.
interface spike_tag_fifo_if #(
  parameter int tagbits   = 1,
  parameter int depthbits = 2
);
  logic                 push;
  logic [tagbits-1:0]   push_tag;
  logic                 req_deq;
  logic [tagbits-1:0]   fired_tag;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [depthbits:0]   count;
  logic                 overflow;

  modport master (
    output push, push_tag, req_deq,
    input  fired_tag, fifo_empty, fifo_full, count, overflow
  );

  modport slave (
    input  push, push_tag, req_deq,
    output fired_tag, fifo_empty, fifo_full, count, overflow
  );
endinterface

// File: rtl/spike_tag_fifo.sv
// spike_tag_fifo: first-word-fall-through queue of fired-neuron tags between
// the neuron-update stage (push side) and the synaptic-accumulate stage
// (pop side). Status outputs are registered; fired_tag is a combinational
// show-ahead of the head entry and reads as zero while the queue is empty.
//
// Optional feature: define SPIKE_TAG_FIFO_DEDUP_EN to keep a pending bit per
// neuron so a tag that is already queued is not queued a second time.
module spike_tag_fifo #(
  parameter int tagbits    = 1,
  parameter int numneurons = 2,
  parameter int depthbits  = 2
) (
  input  logic                  clk,
  input  logic                  asyn_reset_n,
  spike_tag_fifo_if.slave       bus
);

  localparam int DEPTH = 1 << depthbits;
  localparam logic [depthbits:0] FULL_COUNT = (depthbits+1)'(DEPTH);

  // Storage and pointers. Pointers wrap naturally at 2**depthbits.
  logic [tagbits-1:0]   r_mem [DEPTH];
  logic [depthbits-1:0] r_rd_ptr;
  logic [depthbits-1:0] r_wr_ptr;
  logic [depthbits:0]   r_count;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_overflow;

  logic [tagbits-1:0]   w_head;
  logic                 w_pop;
  logic                 w_room;
  logic                 w_dup;
  logic                 w_push_acc;
  logic                 w_drop_full;
  logic [depthbits:0]   w_count_next;

  // Raw head entry; only meaningful while the queue is non-empty.
  assign w_head = r_mem[r_rd_ptr];

  // A pop only happens when there is something to pop; a push arriving into
  // an empty queue is never popped in the same cycle because r_empty is the
  // pre-edge state.
  assign w_pop = bus.req_deq && !r_empty;

  // A full queue still has room this cycle if the head leaves at the same edge.
  assign w_room = !r_full || w_pop;

`ifdef SPIKE_TAG_FIFO_DEDUP_EN
  // One pending bit per addressable neuron: set while that tag sits in the queue.
  logic [numneurons-1:0] r_pending;
  logic [numneurons-1:0] w_hit;
  logic [numneurons-1:0] w_pop_hit;
  logic [numneurons-1:0] w_push_hit;

  for (genvar gi = 0; gi < numneurons; gi++) begin : g_pending
    // Does the head entry leaving this cycle carry neuron gi's tag?
    assign w_pop_hit[gi]  = w_pop && (w_head == tagbits'(gi));
    // Is the accepted push neuron gi's tag?
    assign w_push_hit[gi] = w_push_acc && (bus.push_tag == tagbits'(gi));
    // A pending tag blocks a new push unless that very tag leaves this cycle.
    assign w_hit[gi] = r_pending[gi] && (bus.push_tag == tagbits'(gi)) &&
                       !w_pop_hit[gi];

    // Pending bit: set on accepted push, cleared on pop; a same-cycle pop and
    // push of the same tag leaves it set.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
      if (!asyn_reset_n) begin
        r_pending[gi] <= 1'b0;
      end else if (w_push_hit[gi]) begin
        r_pending[gi] <= 1'b1;
      end else if (w_pop_hit[gi]) begin
        r_pending[gi] <= 1'b0;
      end
    end
  end

  assign w_dup = |w_hit;
`else
  // Without deduplication every tag is queued as a normal entry.
  assign w_dup = 1'b0;
`endif

  // Push acceptance and the full-drop condition. A duplicate drop is silent
  // and does not count as an overflow.
  assign w_push_acc  = bus.push && w_room && !w_dup;
  assign w_drop_full = bus.push && !w_room && !w_dup;

  // Next entry count from the accepted push and pop of this cycle.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_acc, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage write; contents are deliberately left uncleared by reset since
  // the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= bus.push_tag;
    end
  end

  // Pointers, registered count/flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == FULL_COUNT);
      if (w_drop_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Outputs: show-ahead head tag masked to zero while empty.
  assign bus.fired_tag  = r_empty ? '0 : w_head;
  assign bus.fifo_empty = r_empty;
  assign bus.fifo_full  = r_full;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_spike_tag_fifo.sv
// Directed bench for spike_tag_fifo with default parameters
// (tagbits=1, numneurons=2, depthbits=2). Honours SPIKE_TAG_FIFO_DEDUP_EN.
module tb_spike_tag_fifo;
  localparam int TB = 1;
  localparam int DB = 2;

  logic clk;
  logic asyn_reset_n;
  int   vectors;
  int   miscompares;

  spike_tag_fifo_if #(.tagbits(TB), .depthbits(DB)) bus ();

  spike_tag_fifo #(.tagbits(TB), .numneurons(2), .depthbits(DB)) dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  // One clock cycle with the given push/pop inputs; outputs sampled 1 ns after the edge.
  task automatic cyc(input logic p, input logic [TB-1:0] t, input logic d);
    bus.push     = p;
    bus.push_tag = t;
    bus.req_deq  = d;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.req_deq = 1'b0;
  endtask

  // Pop the head entry after checking it carries the expected tag.
  task automatic pop_expect(input string tag, input logic [TB-1:0] exp_tag);
    chk(tag, 32'(bus.fired_tag), 32'(exp_tag));
    cyc(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    asyn_reset_n = 1'b0;
    @(posedge clk);
    #3;
    asyn_reset_n = 1'b1;
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    bus.push     = 1'b0;
    bus.push_tag = '0;
    bus.req_deq  = 1'b0;
    asyn_reset_n = 1'b1;
    #2;
    do_reset();

    chk("rst_count",    32'(bus.count), 0);
    chk("rst_empty",    32'(bus.fifo_empty), 1);
    chk("rst_full",     32'(bus.fifo_full), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_fired",    32'(bus.fired_tag), 0);

`ifndef SPIKE_TAG_FIFO_DEDUP_EN
    // Push 1,0,1 then drain in order.
    cyc(1'b1, 1'b1, 1'b0);
    chk("p1_count", 32'(bus.count), 1);
    chk("p1_fired", 32'(bus.fired_tag), 1);
    chk("p1_empty", 32'(bus.fifo_empty), 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("p3_count", 32'(bus.count), 3);
    chk("p3_fired", 32'(bus.fired_tag), 1);
    pop_expect("ord_a0", 1'b1);
    pop_expect("ord_a1", 1'b0);
    pop_expect("ord_a2", 1'b1);
    chk("drain_empty", 32'(bus.fifo_empty), 1);
    chk("drain_count", 32'(bus.count), 0);
    chk("drain_fired", 32'(bus.fired_tag), 0);

    // Fill to full, then push+pop while full (no overflow), then overflow.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("f3_full", 32'(bus.fifo_full), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("f4_full",  32'(bus.fifo_full), 1);
    chk("f4_count", 32'(bus.count), 4);
    chk("f4_ovf",   32'(bus.overflow), 0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("fpp_count", 32'(bus.count), 4);
    chk("fpp_full",  32'(bus.fifo_full), 1);
    chk("fpp_ovf",   32'(bus.overflow), 0);
    chk("fpp_fired", 32'(bus.fired_tag), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("ovf_flag",  32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 4);
    chk("ovf_fired", 32'(bus.fired_tag), 0);
    // Queue is 0,0,1,0; the dropped 1 must not appear.
    pop_expect("ord_b0", 1'b0);
    pop_expect("ord_b1", 1'b0);
    pop_expect("ord_b2", 1'b1);
    pop_expect("ord_b3", 1'b0);
    chk("b_empty", 32'(bus.fifo_empty), 1);
    chk("b_ovf_sticky", 32'(bus.overflow), 1);

    // Pop requests while empty are ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("edeq_count", 32'(bus.count), 0);
      chk("edeq_empty", 32'(bus.fifo_empty), 1);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk("epush_count", 32'(bus.count), 1);
    chk("epush_fired", 32'(bus.fired_tag), 1);
    // Non-full simultaneous push and pop.
    cyc(1'b1, 1'b0, 1'b1);
    chk("pp_count", 32'(bus.count), 1);
    chk("pp_fired", 32'(bus.fired_tag), 0);
    pop_expect("pp_last", 1'b0);
    chk("pp_empty", 32'(bus.fifo_empty), 1);

    // Mid-cycle reset with three entries queued.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 3);
    #2;
    asyn_reset_n = 1'b0;
    #1;
    chk("mrst_count", 32'(bus.count), 0);
    chk("mrst_empty", 32'(bus.fifo_empty), 1);
    chk("mrst_full",  32'(bus.fifo_full), 0);
    chk("mrst_fired", 32'(bus.fired_tag), 0);
    chk("mrst_ovf",   32'(bus.overflow), 0);
    #1;
    asyn_reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("post_rst_count", 32'(bus.count), 1);
    chk("post_rst_fired", 32'(bus.fired_tag), 0);
    pop_expect("post_rst_pop", 1'b0);
    chk("post_rst_empty", 32'(bus.fifo_empty), 1);
    chk("post_rst_fired0", 32'(bus.fired_tag), 0);
`else
    // Duplicate suppression: 1,1,0 queues as 1,0.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("dd_count", 32'(bus.count), 2);
    chk("dd_ovf",   32'(bus.overflow), 0);
    pop_expect("dd_ord0", 1'b1);
    chk("dd_fired", 32'(bus.fired_tag), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("dd_repush_count", 32'(bus.count), 2);
    pop_expect("dd_ord1", 1'b0);
    pop_expect("dd_ord2", 1'b1);
    chk("dd_empty", 32'(bus.fifo_empty), 1);
    // Same-cycle pop and push of the same tag keeps it pending.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("dd_same_count", 32'(bus.count), 1);
    chk("dd_same_fired", 32'(bus.fired_tag), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("dd_still_pending", 32'(bus.count), 1);
    chk("dd_no_ovf", 32'(bus.overflow), 0);
    pop_expect("dd_last", 1'b1);
    chk("dd_end_empty", 32'(bus.fifo_empty), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spike_tag_fifo.md
SPIKE_TAG_FIFO -- requirements
Module: spike_tag_fifo

Interface
REQ-001 SHALL have parameter tagbits, default 1, width of a neuron tag.
REQ-002 SHALL have parameter numneurons, default 2, number of addressable neuron tags.
REQ-003 SHALL have parameter depthbits, default 2, giving a FIFO depth of 2**depthbits entries.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port asyn_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port push, input, 1, a neuron-update stage reports a fired neuron this cycle.
REQ-007 SHALL have port push_tag, input, tagbits, the tag of the fired neuron.
REQ-008 SHALL have port req_deq, input, 1, the synaptic-accumulate stage consumes the head entry.
REQ-009 SHALL have port fired_tag, output, tagbits, the head-of-queue tag (show-ahead).
REQ-010 SHALL have port fifo_empty, output, 1, high when the entry count is 0.
REQ-011 SHALL have port fifo_full, output, 1, high when the entry count is 2**depthbits.
REQ-012 SHALL have port count, output, depthbits+1, the current entry count.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when a push is dropped because the FIFO is full.

Function
REQ-014 SHALL be a first-word-fall-through FIFO: fired_tag combinationally equals the entry at the read pointer whenever fifo_empty is low, with no read latency.
REQ-015 SHALL drive fired_tag to all zeros while fifo_empty is high.
REQ-016 SHALL accept a push when push=1 and (fifo_full=0 or req_deq=1 with fifo_empty=0), writing push_tag at the write pointer; the entry is visible on fired_tag from the next cycle.
REQ-017 SHALL pop on req_deq=1 with fifo_empty=0 by advancing the read pointer at the clock edge; req_deq while empty SHALL be ignored without pointer or count change.
REQ-018 SHALL, on simultaneous accepted push and pop, keep count unchanged and advance both pointers; a push into an empty FIFO with req_deq=1 SHALL NOT be popped in the same cycle.
REQ-019 SHALL wrap both pointers modulo 2**depthbits; full/empty SHALL be derived from count, not from pointer equality alone.
REQ-020 SHALL, when push=1 while full with no pop, drop push_tag, leave all state unchanged, and set overflow to 1 at that edge.
REQ-021 SHALL keep overflow set until reset.
REQ-022 SHALL register count, fifo_empty and fifo_full so they reflect the state after each edge, with no combinational path from push or req_deq.
REQ-023 SHALL preserve ordering: tags leave in exactly the order they were accepted.

Reset
REQ-024 SHALL, while asyn_reset_n=0, immediately clear the read and write pointers, count=0, fifo_empty=1, fifo_full=0, overflow=0, fired_tag=0, and any dedup state.
REQ-025 SHALL discard all entries on reset mid-operation; storage contents need not be cleared.
REQ-026 SHALL accept its first push on the first rising edge after asyn_reset_n goes high.

Configuration
REQ-027 SHALL, when macro SPIKE_TAG_FIFO_DEDUP_EN is defined, keep a numneurons-bit pending vector: a bit is set on accepted push of that tag and cleared on pop of that tag; a push whose tag is already pending SHALL be dropped silently without setting overflow.
REQ-028 SHALL, on the same-cycle pop and push of an identical tag with SPIKE_TAG_FIFO_DEDUP_EN defined, accept the push and leave the pending bit set.
REQ-029 SHALL, without SPIKE_TAG_FIFO_DEDUP_EN, omit the pending vector and accept duplicate tags as normal entries.

Verification
REQ-030 SHALL pass this scenario: reset, push tags 1,0,1 on consecutive cycles -> count=3, fired_tag=1, and req_deq three times yields 1,0,1 then fifo_empty=1.
REQ-031 SHALL pass this scenario: depthbits=2, push 5 tags with no pop -> fifo_full=1 after the 4th, 5th dropped, overflow=1, count=4.
REQ-032 SHALL pass this scenario: full FIFO, push and req_deq in the same cycle -> push accepted, count stays 4, overflow stays 0.
REQ-033 SHALL pass this scenario: empty FIFO, req_deq=1 for 3 cycles -> count=0 and pointers unchanged; then push 1 with req_deq=1 -> count=1, fired_tag=1 next cycle.
REQ-034 SHALL pass this scenario: 3 entries queued, asyn_reset_n pulsed low mid-cycle -> outputs at reset values immediately, with no pre-reset tag ever appearing afterwards.
REQ-035 SHALL pass this scenario: with SPIKE_TAG_FIFO_DEDUP_EN defined, push 1,1,0 -> count=2, output order 1,0; after popping 1, a push of 1 is accepted.
